// File: rtl/eviction_write_buffer.sv
// Eviction write buffer between the L2 memory port and physical memory.
// Dirty-line writebacks are absorbed into a small line buffer in one cycle
// and drained to memory oldest-first in the background. L2 reads hit in the
// buffer (youngest matching entry) or are forwarded to memory.
module eviction_write_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         l2cmem_read,
    input  logic         l2cmem_write,
    input  logic [31:0]  l2cmem_address,
    input  logic [255:0] l2cmem_wdata,
    output logic [255:0] l2cmem_rdata,
    output logic         l2cmem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] READ_MEM = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;

    logic [1:0]      state;
    logic [DEPTH-1:0] valid_q;
    logic [26:0]     tag_q  [DEPTH];
    logic [255:0]    data_q [DEPTH];
    logic [IW-1:0]   age_q  [DEPTH];
    logic [IW-1:0]   drain_idx;

    logic [26:0]     req_tag;
    logic            addr_lsb_unused;

    logic            hit;
    logic [IW-1:0]   hit_idx;
    logic [IW-1:0]   hit_age;
    logic            coal;
    logic [IW-1:0]   coal_idx;
    logic            free_any;
    logic [IW-1:0]   free_idx;
    logic            nonempty;
    logic [IW-1:0]   old_idx;
    logic [IW-1:0]   old_age;

    logic            wr_req;
    logic            rd_req;
    logic            wr_state_ok;
    logic            do_coal;
    logic            do_alloc;
    logic            do_rd_hit;
    logic            rd_miss;
    logic            start_read;
    logic            start_drain;

    assign req_tag         = l2cmem_address[31:5];
    assign addr_lsb_unused = ^l2cmem_address[4:0];

    // Buffer lookup: youngest read match, non-busy coalesce target, first free slot, oldest entry
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_age  = '0;
        coal     = 1'b0;
        coal_idx = '0;
        free_any = 1'b0;
        free_idx = '0;
        nonempty = 1'b0;
        old_idx  = '0;
        old_age  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                if (!nonempty || age_q[i] > old_age) begin
                    old_idx = IW'(i);
                    old_age = age_q[i];
                end
                nonempty = 1'b1;
                if (tag_q[i] == req_tag) begin
                    if (!hit || age_q[i] < hit_age) begin
                        hit_idx = IW'(i);
                        hit_age = age_q[i];
                    end
                    hit = 1'b1;
                    if (!(state == DRAIN && drain_idx == IW'(i))) begin
                        coal     = 1'b1;
                        coal_idx = IW'(i);
                    end
                end
            end else if (!free_any) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    // Request decode; the held request is ignored during the response cycle
    always_comb begin
        wr_req      = !l2cmem_resp && l2cmem_write;
        rd_req      = !l2cmem_resp && l2cmem_read && !l2cmem_write;
        wr_state_ok = (state == IDLE) || (state == DRAIN);
        do_coal     = wr_req && wr_state_ok && coal;
        do_alloc    = wr_req && wr_state_ok && !coal && free_any;
        do_rd_hit   = rd_req && hit;
        rd_miss     = rd_req && !hit;
        start_read  = (state == IDLE) && rd_miss;
        start_drain = (state == IDLE) && !rd_miss && nonempty;
    end

    // Line tag/data storage; contents are meaningless while the entry is invalid
    always_ff @(posedge clk) begin
        if (do_coal) begin
            data_q[coal_idx] <= l2cmem_wdata;
        end else if (do_alloc) begin
            data_q[free_idx] <= l2cmem_wdata;
            tag_q[free_idx]  <= req_tag;
        end
    end

    // Entry valid/age bookkeeping: allocation ages older entries, drain completion frees
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            if (do_alloc) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (valid_q[i]) begin
                        age_q[i] <= age_q[i] + 1'b1;
                    end
                end
                valid_q[free_idx] <= 1'b1;
                age_q[free_idx]   <= '0;
            end
            if (state == DRAIN && pmem_resp) begin
                valid_q[drain_idx] <= 1'b0;
            end
        end
    end

    // Control FSM plus registered L2 response and memory request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            drain_idx    <= '0;
            l2cmem_resp  <= 1'b0;
            l2cmem_rdata <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            l2cmem_resp <= do_coal || do_alloc || do_rd_hit ||
                           (state == READ_MEM && pmem_resp);
            if (do_rd_hit) begin
                l2cmem_rdata <= data_q[hit_idx];
            end
            case (state)
                IDLE: begin
                    if (start_read) begin
                        state        <= READ_MEM;
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, 5'b0};
                    end else if (start_drain) begin
                        state        <= DRAIN;
                        pmem_write   <= 1'b1;
                        drain_idx    <= old_idx;
                        pmem_address <= {tag_q[old_idx], 5'b0};
                        // A write coalescing into the entry chosen for drain on this
                        // same edge must reach memory, so forward its data.
                        pmem_wdata   <= (do_coal && coal_idx == old_idx) ?
                                        l2cmem_wdata : data_q[old_idx];
                    end
                end
                READ_MEM: begin
                    if (pmem_resp) begin
                        state        <= IDLE;
                        pmem_read    <= 1'b0;
                        l2cmem_rdata <= pmem_rdata;
                    end
                end
                DRAIN: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
